// File: rtl/tdoa_result_averager.sv
// Averages 2**LOG2_AVG in-window correlator lag pairs and re-arms the correlator after each event.
// Edge to result_valid/correlator_reset in 2 cycles; result held until result_ready. Option: TDOA_REJECT_COUNT_EN.
module tdoa_result_averager #(
   parameter int CENTER       = 128,
   parameter int MAX_LAG      = 40,
   parameter int LOG2_AVG     = 2,
   parameter int REARM_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       done,
   input  logic [7:0] offset_1,
   input  logic [7:0] offset_2,
   output logic       correlator_reset,
   output logic       result_valid,
   input  logic       result_ready,
   output logic [8:0] lag_1,
   output logic [8:0] lag_2
`ifdef TDOA_REJECT_COUNT_EN
   ,
   output logic [15:0] reject_count
`endif
);

   localparam int ACC_W = 9 + LOG2_AVG;
   localparam int CNT_W = LOG2_AVG + 1;
   localparam int RA_W  = $clog2(REARM_CYCLES + 1);

   localparam logic        [8:0]       LP_CENTER = 9'(CENTER);
   localparam logic signed [8:0]       LP_MAX    = 9'(MAX_LAG);
   localparam logic signed [8:0]       LP_MIN    = 9'(-MAX_LAG);
   localparam logic        [CNT_W-1:0] LP_AVG_N  = CNT_W'(2 ** LOG2_AVG);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_OUTPUT, S_REARM} state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic                     r_done_q;
   logic [7:0]               r_off_1;
   logic [7:0]               r_off_2;
   logic signed [ACC_W-1:0]  r_acc_1;
   logic signed [ACC_W-1:0]  r_acc_2;
   logic [CNT_W-1:0]         r_cnt;
   logic [RA_W-1:0]          r_rearm;
   logic [8:0]               r_lag_1;
   logic [8:0]               r_lag_2;

   logic                     w_event;
   logic signed [8:0]        w_lag_1;
   logic signed [8:0]        w_lag_2;
   logic                     w_reject;
   logic signed [ACC_W-1:0]  w_acc_1;
   logic signed [ACC_W-1:0]  w_acc_2;
   logic [CNT_W-1:0]         w_cnt_inc;
   logic                     w_full;
   logic [8:0]               w_avg_1;
   logic [8:0]               w_avg_2;

   assign w_event   = done & ~r_done_q & (r_state == S_IDLE);
   assign w_lag_1   = {1'b0, r_off_1} - LP_CENTER;
   assign w_lag_2   = {1'b0, r_off_2} - LP_CENTER;
   assign w_reject  = (w_lag_1 > LP_MAX) || (w_lag_1 < LP_MIN) ||
                      (w_lag_2 > LP_MAX) || (w_lag_2 < LP_MIN);
   // Size casts of signed lags sign-extend into the accumulator width.
   assign w_acc_1   = r_acc_1 + ACC_W'(w_lag_1);
   assign w_acc_2   = r_acc_2 + ACC_W'(w_lag_2);
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_full    = (w_cnt_inc == LP_AVG_N);
   assign w_avg_1   = 9'(w_acc_1 >>> LOG2_AVG);
   assign w_avg_2   = 9'(w_acc_2 >>> LOG2_AVG);

   assign lag_1 = r_lag_1;
   assign lag_2 = r_lag_2;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next           = r_state;
      result_valid     = 1'b0;
      correlator_reset = 1'b0;
      case (r_state)
         S_IDLE:   if (w_event) w_next = S_CHECK;
         S_CHECK:  w_next = (!w_reject && w_full) ? S_OUTPUT : S_REARM;
         S_OUTPUT: begin
            result_valid = 1'b1;
            if (result_ready) w_next = S_REARM;
         end
         S_REARM:  begin
            correlator_reset = 1'b1;
            if (r_rearm == '0) w_next = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_done_q <= 1'b0;
         r_off_1  <= '0;
         r_off_2  <= '0;
         r_acc_1  <= '0;
         r_acc_2  <= '0;
         r_cnt    <= '0;
         r_rearm  <= '0;
         r_lag_1  <= '0;
         r_lag_2  <= '0;
      end else begin
         r_done_q <= done;
         if (w_event) begin
            r_off_1 <= offset_1;
            r_off_2 <= offset_2;
         end
         if (r_state == S_CHECK && !w_reject) begin
            r_acc_1 <= w_acc_1;
            r_acc_2 <= w_acc_2;
            r_cnt   <= w_cnt_inc;
            if (w_full) begin
               r_lag_1 <= w_avg_1;
               r_lag_2 <= w_avg_2;
            end
         end
         if (r_state == S_OUTPUT && result_ready) begin
            r_acc_1 <= '0;
            r_acc_2 <= '0;
            r_cnt   <= '0;
         end
         // Loaded on REARM entry so the pulse lasts exactly REARM_CYCLES.
         if (w_next == S_REARM && r_state != S_REARM)
            r_rearm <= RA_W'(REARM_CYCLES - 1);
         else if (r_state == S_REARM && r_rearm != '0)
            r_rearm <= r_rearm - RA_W'(1);
      end
   end

`ifdef TDOA_REJECT_COUNT_EN
   logic [15:0] r_reject_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_reject_count <= '0;
      else if (r_state == S_CHECK && w_reject && r_reject_count != 16'hFFFF)
         r_reject_count <= r_reject_count + 16'd1;
   end

   assign reject_count = r_reject_count;
`endif

endmodule

// File: tb/tb_tdoa_result_averager.sv
// Directed bench for tdoa_result_averager with a reference model feeding a result scoreboard.
module tb_tdoa_result_averager;

   localparam int CENTER  = 128;
   localparam int MAX_LAG = 40;
   localparam int AVG_N   = 4;

   typedef struct packed {
      logic [8:0] l1;
      logic [8:0] l2;
   } res_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       done = 1'b0;
   logic [7:0] offset_1 = 8'd0;
   logic [7:0] offset_2 = 8'd0;
   logic       correlator_reset;
   logic       result_valid;
   logic       result_ready = 1'b0;
   logic [8:0] lag_1;
   logic [8:0] lag_2;
`ifdef TDOA_REJECT_COUNT_EN
   logic [15:0] reject_count;
`endif

   int   errors = 0;
   int   checks = 0;
   int   m_acc1 = 0;
   int   m_acc2 = 0;
   int   m_cnt  = 0;
   int   m_rej  = 0;
   res_t sb_q[$];
   res_t last_res;

   always #5 clk = ~clk;

   tdoa_result_averager dut (
      .clk              (clk),
      .reset            (reset),
      .done             (done),
      .offset_1         (offset_1),
      .offset_2         (offset_2),
      .correlator_reset (correlator_reset),
      .result_valid     (result_valid),
      .result_ready     (result_ready),
      .lag_1            (lag_1),
      .lag_2            (lag_2)
`ifdef TDOA_REJECT_COUNT_EN
      ,
      .reject_count     (reject_count)
`endif
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: returns 1 when this event should complete an average.
   task automatic model_event(input logic [7:0] o1, input logic [7:0] o2, output bit out);
      int l1, l2;
      res_t r;
      l1  = int'(o1) - CENTER;
      l2  = int'(o2) - CENTER;
      out = 1'b0;
      if (l1 > MAX_LAG || l1 < -MAX_LAG || l2 > MAX_LAG || l2 < -MAX_LAG) begin
         m_rej++;
      end else begin
         m_acc1 += l1;
         m_acc2 += l2;
         m_cnt++;
         if (m_cnt == AVG_N) begin
            r.l1 = 9'(m_acc1 >>> 2);
            r.l2 = 9'(m_acc2 >>> 2);
            sb_q.push_back(r);
            m_acc1 = 0;
            m_acc2 = 0;
            m_cnt  = 0;
            out    = 1'b1;
         end
      end
   endtask

   // Called at a negedge where correlator_reset is expected to have just risen.
   task automatic count_rearm(input string tag);
      int n;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (correlator_reset) n++;
         else break;
         @(negedge clk);
      end
      chk(tag, 16'(n), 16'd4);
   endtask

   task automatic do_event(input logic [7:0] o1, input logic [7:0] o2, input string tag,
                           output bit out);
      res_t r;
      model_event(o1, o2, out);
      @(posedge clk); #1;
      offset_1 = o1;
      offset_2 = o2;
      done     = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_valid"}, 16'(result_valid), 16'(out));
      chk({tag, "_crst"}, 16'(correlator_reset), 16'(!out));
      if (out) begin
         if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
         end else begin
            r = sb_q.pop_front();
            last_res = r;
            chk({tag, "_lag1"}, 16'(lag_1), 16'(r.l1));
            chk({tag, "_lag2"}, 16'(lag_2), 16'(r.l2));
         end
      end else begin
         count_rearm({tag, "_rearm"});
      end
   endtask

   task automatic accept(input string tag);
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_vdrop"}, 16'(result_valid), 16'd0);
      count_rearm({tag, "_rearm"});
   endtask

   initial begin
      bit out;
      int nr, nv;
      last_res = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", 16'(result_valid), 16'd0);
      chk("rst_crst", 16'(correlator_reset), 16'd0);
      chk("rst_lag1", 16'(lag_1), 16'd0);
      chk("rst_lag2", 16'(lag_2), 16'd0);

      // 1: basic average, lags 3 / -6
      do_event(8'd130, 8'd120, "t1e1", out);
      do_event(8'd134, 8'd118, "t1e2", out);
      do_event(8'd128, 8'd126, "t1e3", out);
      do_event(8'd132, 8'd124, "t1e4", out);
      chk("t1_lag1_const", 16'(lag_1), 16'(9'd3));
      chk("t1_lag2_const", 16'(lag_2), 16'(9'h1FA));
      accept("t1");

      // 2: floor of -1.5 is -2
      do_event(8'd127, 8'd128, "t2e1", out);
      do_event(8'd126, 8'd128, "t2e2", out);
      do_event(8'd125, 8'd128, "t2e3", out);
      do_event(8'd128, 8'd128, "t2e4", out);
      chk("t2_lag1_const", 16'(lag_1), 16'(9'h1FE));
      accept("t2");

      // 3: window boundaries
      do_event(8'd200, 8'd128, "t3_200", out);
      do_event(8'd168, 8'd128, "t3_168", out);
      do_event(8'd88,  8'd128, "t3_88", out);
      do_event(8'd87,  8'd128, "t3_87", out);
      do_event(8'd131, 8'd125, "t3e5", out);
      do_event(8'd129, 8'd127, "t3e6", out);
      chk("t3_out", 16'(out), 16'd1);
`ifdef TDOA_REJECT_COUNT_EN
      chk("t3_rejcnt", reject_count, 16'(m_rej));
`endif
      accept("t3");

      // 4: hold off the consumer while done toggles
      do_event(8'd140, 8'd120, "t4e1", out);
      do_event(8'd141, 8'd119, "t4e2", out);
      do_event(8'd142, 8'd118, "t4e3", out);
      do_event(8'd143, 8'd117, "t4e4", out);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         done = ~done;
         @(negedge clk);
         chk("t4_hold_valid", 16'(result_valid), 16'd1);
         chk("t4_hold_lag1", 16'(lag_1), 16'(last_res.l1));
         chk("t4_hold_lag2", 16'(lag_2), 16'(last_res.l2));
      end
      done = 1'b0;
      accept("t4");

      // 5: reset during REARM discards two accumulated events
      do_event(8'd150, 8'd110, "t5e1", out);
      @(posedge clk); #1;
      offset_1 = 8'd160;
      offset_2 = 8'd100;
      done     = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t5_in_rearm", 16'(correlator_reset), 16'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("t5_rst_crst", 16'(correlator_reset), 16'd0);
      chk("t5_rst_valid", 16'(result_valid), 16'd0);
      chk("t5_rst_lag1", 16'(lag_1), 16'd0);
      chk("t5_rst_lag2", 16'(lag_2), 16'd0);
`ifdef TDOA_REJECT_COUNT_EN
      chk("t5_rst_rejcnt", reject_count, 16'd0);
      m_rej = 0;
`endif
      m_acc1 = 0;
      m_acc2 = 0;
      m_cnt  = 0;
      sb_q.delete();
      do_event(8'd138, 8'd118, "t5f1", out);
      do_event(8'd140, 8'd116, "t5f2", out);
      do_event(8'd136, 8'd120, "t5f3", out);
      do_event(8'd134, 8'd122, "t5f4", out);
      accept("t5");

      // 6: done held high yields a single capture
      model_event(8'd130, 8'd128, out);
      @(posedge clk); #1;
      offset_1 = 8'd130;
      offset_2 = 8'd128;
      done     = 1'b1;
      nr = 0;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (correlator_reset) nr++;
         if (result_valid) nv++;
      end
      chk("t6_rearm_cycles", 16'(nr), 16'd4);
      chk("t6_no_valid", 16'(nv), 16'd0);
      done = 1'b0;
      repeat (2) @(posedge clk);
      do_event(8'd126, 8'd128, "t6_second", out);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
